// File: rtl/sync_fifo_pack_if.sv
// Handshake and status bundle for sync_fifo_pack: narrow write side, wide read side.
interface sync_fifo_pack_if #(
    parameter int unsigned INPUT_WIDTH  = 8,
    parameter int unsigned OUTPUT_WIDTH = 64,
    parameter int unsigned WR_DEPTH     = 128,
    parameter int unsigned RD_DEPTH     = 16
);
    logic                          wr_en;
    logic [INPUT_WIDTH-1:0]        din;
    logic                          full;
    logic [$clog2(WR_DEPTH):0]     wr_data_count;
    logic [$clog2(WR_DEPTH):0]     wr_data_space;
    logic                          rd_en;
    logic [OUTPUT_WIDTH-1:0]       dout;
    logic                          valid;
    logic                          empty;
    logic [$clog2(RD_DEPTH):0]     rd_data_count;
    logic [$clog2(RD_DEPTH):0]     rd_data_space;

    modport master (
        output wr_en, din, rd_en,
        input  full, wr_data_count, wr_data_space,
        input  dout, valid, empty, rd_data_count, rd_data_space
    );

    modport slave (
        input  wr_en, din, rd_en,
        output full, wr_data_count, wr_data_space,
        output dout, valid, empty, rd_data_count, rd_data_space
    );
endinterface

// File: rtl/sync_fifo_pack.sv
// Single-clock packing FIFO: RATIO narrow write words are assembled into one wide read word.
// Storage is kept as wide rows so a read never needs more than one row access.
module sync_fifo_pack #(
    parameter int unsigned INPUT_WIDTH  = 8,
    parameter int unsigned OUTPUT_WIDTH = 64,
    parameter int unsigned WR_DEPTH     = 128,
    parameter int unsigned RD_DEPTH     = 16,
    parameter string       MODE         = "Standard",
    parameter string       DIRECTION    = "LSB"
) (
    input  logic             sys_clk,
    input  logic             sys_rst,
    sync_fifo_pack_if.slave  fifo
);
    localparam int unsigned RATIO = OUTPUT_WIDTH / INPUT_WIDTH;
    localparam int unsigned LOG_R = $clog2(RATIO);
    localparam int unsigned WA    = $clog2(WR_DEPTH);
    localparam int unsigned RA    = $clog2(RD_DEPTH);
    localparam int unsigned WCW   = WA + 1;
    localparam int unsigned RCW   = RA + 1;

    logic [OUTPUT_WIDTH-1:0] mem_q [RD_DEPTH];

    logic [WA-1:0]           wr_ptr_q;
    logic [RA-1:0]           rd_ptr_q;
    logic [WCW-1:0]          wcnt_q, wcnt_d;
    logic [WCW-1:0]          wspace_q, wspace_d;
    logic [WCW-1:0]          wceil_d;
    logic [RCW-1:0]          rcnt_q, rcnt_d;
    logic [RCW-1:0]          rspace_q, rspace_d;
    logic                    full_q, full_d;
    logic                    empty_q, empty_d;
    logic                    wr_acc, rd_acc;

    logic [RA-1:0]           wr_row;
    logic [LOG_R-1:0]        wr_lane, lane_pos;
    logic [31:0]             wr_shift;
    logic [OUTPUT_WIDTH-1:0] lane_mask, lane_data, head;

    assign wr_row    = wr_ptr_q[WA-1:LOG_R];
    assign wr_lane   = wr_ptr_q[LOG_R-1:0];
    assign lane_pos  = (DIRECTION == "MSB") ? ~wr_lane : wr_lane;
    assign wr_shift  = 32'(lane_pos) * INPUT_WIDTH;
    assign lane_mask = {{(OUTPUT_WIDTH-INPUT_WIDTH){1'b0}}, {INPUT_WIDTH{1'b1}}} << wr_shift;
    assign lane_data = {{(OUTPUT_WIDTH-INPUT_WIDTH){1'b0}}, fifo.din} << wr_shift;
    assign head      = mem_q[rd_ptr_q];

    // A read at full frees a whole row, so a same-edge write is accepted into that space.
    always_comb begin
        rd_acc = fifo.rd_en & ~empty_q;
        wr_acc = fifo.wr_en & (~full_q | rd_acc);

        wcnt_d = wcnt_q;
        if (wr_acc) wcnt_d = wcnt_d + WCW'(1);
        if (rd_acc) wcnt_d = wcnt_d - WCW'(RATIO);

        wceil_d  = wcnt_d + WCW'(RATIO - 1);
        rcnt_d   = RCW'(wcnt_d >> LOG_R);
        rspace_d = RCW'(RD_DEPTH) - RCW'(wceil_d >> LOG_R);
        wspace_d = WCW'(WR_DEPTH) - wcnt_d;
        full_d   = (wcnt_d == WCW'(WR_DEPTH));
        empty_d  = (wcnt_d < WCW'(RATIO));
    end

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            wcnt_q   <= '0;
            rcnt_q   <= '0;
            wspace_q <= WCW'(WR_DEPTH);
            rspace_q <= RCW'(RD_DEPTH);
            full_q   <= 1'b0;
            empty_q  <= 1'b1;
        end else begin
            if (wr_acc) wr_ptr_q <= wr_ptr_q + WA'(1);
            if (rd_acc) rd_ptr_q <= rd_ptr_q + RA'(1);
            wcnt_q   <= wcnt_d;
            rcnt_q   <= rcnt_d;
            wspace_q <= wspace_d;
            rspace_q <= rspace_d;
            full_q   <= full_d;
            empty_q  <= empty_d;
        end
    end

    always_ff @(posedge sys_clk) begin
        if (!sys_rst && wr_acc)
            mem_q[wr_row] <= (mem_q[wr_row] & ~lane_mask) | lane_data;
    end

    generate
        if (MODE == "FWFT") begin : g_fwft
            assign fifo.dout  = empty_q ? '0 : head;
            assign fifo.valid = ~empty_q;
        end else begin : g_std
            logic [OUTPUT_WIDTH-1:0] dout_q;
            logic                    valid_q;

            always_ff @(posedge sys_clk) begin
                if (sys_rst) begin
                    dout_q  <= '0;
                    valid_q <= 1'b0;
                end else begin
                    valid_q <= rd_acc;
                    if (rd_acc) dout_q <= head;
                end
            end

            assign fifo.dout  = dout_q;
            assign fifo.valid = valid_q;
        end
    endgenerate

    assign fifo.full          = full_q;
    assign fifo.empty         = empty_q;
    assign fifo.wr_data_count = wcnt_q;
    assign fifo.wr_data_space = wspace_q;
    assign fifo.rd_data_count = rcnt_q;
    assign fifo.rd_data_space = rspace_q;
endmodule

// File: tb/tb_sync_fifo_pack.sv
// Directed bench for sync_fifo_pack: LSB/Standard instance plus an MSB/Standard instance.
module tb_sync_fifo_pack;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_checks = 0;
    int   n_fail   = 0;

    always #5 clk = ~clk;

    sync_fifo_pack_if #(.INPUT_WIDTH(8), .OUTPUT_WIDTH(64), .WR_DEPTH(128), .RD_DEPTH(16)) bus ();
    sync_fifo_pack_if #(.INPUT_WIDTH(8), .OUTPUT_WIDTH(64), .WR_DEPTH(128), .RD_DEPTH(16)) bus_m ();

    sync_fifo_pack #(
        .INPUT_WIDTH(8), .OUTPUT_WIDTH(64), .WR_DEPTH(128), .RD_DEPTH(16),
        .MODE("Standard"), .DIRECTION("LSB")
    ) dut (
        .sys_clk(clk), .sys_rst(rst), .fifo(bus)
    );

    sync_fifo_pack #(
        .INPUT_WIDTH(8), .OUTPUT_WIDTH(64), .WR_DEPTH(128), .RD_DEPTH(16),
        .MODE("Standard"), .DIRECTION("MSB")
    ) dut_msb (
        .sys_clk(clk), .sys_rst(rst), .fifo(bus_m)
    );

    function automatic logic [63:0] lsb_word(input int unsigned b0);
        logic [63:0] w;
        for (int j = 0; j < 8; j++) w[j*8 +: 8] = 8'(b0 + j);
        return w;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        bus.wr_en = 1'b0;  bus.rd_en = 1'b0;  bus.din = '0;
        bus_m.wr_en = 1'b0; bus_m.rd_en = 1'b0; bus_m.din = '0;
    endtask

    task automatic apply_reset();
        idle();
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    task automatic push(input logic [7:0] d);
        bus.wr_en = 1'b1; bus.din = d;
        tick();
        bus.wr_en = 1'b0;
    endtask

    task automatic pop();
        bus.rd_en = 1'b1;
        tick();
        bus.rd_en = 1'b0;
    endtask

    task automatic test_reset();
        bus.wr_en = 1'b1; bus.rd_en = 1'b1; bus.din = 8'h55;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        idle();
        n_checks++; if ({bus.full, bus.empty, bus.valid} !== 3'b010) begin n_fail++; $display("FAIL reset_flags: got %b expected 010", {bus.full, bus.empty, bus.valid}); end
        n_checks++; if (bus.dout !== 64'h0) begin n_fail++; $display("FAIL reset_dout: got %h expected 0", bus.dout); end
        n_checks++; if (bus.wr_data_count !== 8'd0) begin n_fail++; $display("FAIL reset_wcount: got %0d expected 0", bus.wr_data_count); end
        n_checks++; if (bus.rd_data_count !== 5'd0) begin n_fail++; $display("FAIL reset_rcount: got %0d expected 0", bus.rd_data_count); end
        n_checks++; if (bus.wr_data_space !== 8'd128) begin n_fail++; $display("FAIL reset_wspace: got %0d expected 128", bus.wr_data_space); end
        n_checks++; if (bus.rd_data_space !== 5'd16) begin n_fail++; $display("FAIL reset_rspace: got %0d expected 16", bus.rd_data_space); end
    endtask

    task automatic test_fill();
        apply_reset();
        for (int i = 0; i < 128; i++) begin
            push(8'(i));
            if (i == 126) begin
                n_checks++; if (bus.full !== 1'b0) begin n_fail++; $display("FAIL fill_full_early: got %b expected 0", bus.full); end
            end
        end
        n_checks++; if ({bus.full, bus.empty} !== 2'b10) begin n_fail++; $display("FAIL fill_flags: got %b expected 10", {bus.full, bus.empty}); end
        n_checks++; if (bus.wr_data_count !== 8'd128) begin n_fail++; $display("FAIL fill_wcount: got %0d expected 128", bus.wr_data_count); end
        n_checks++; if (bus.rd_data_count !== 5'd16) begin n_fail++; $display("FAIL fill_rcount: got %0d expected 16", bus.rd_data_count); end
        n_checks++; if ({bus.wr_data_space, bus.rd_data_space} !== 13'd0) begin n_fail++; $display("FAIL fill_space: got %0d/%0d expected 0/0", bus.wr_data_space, bus.rd_data_space); end
        push(8'hAA);
        n_checks++; if ({bus.full, bus.wr_data_count} !== {1'b1, 8'd128}) begin n_fail++; $display("FAIL fill_overflow: got full=%b count=%0d expected full=1 count=128", bus.full, bus.wr_data_count); end
    endtask

    task automatic test_drain();
        bus.rd_en = 1'b1;
        for (int k = 0; k < 16; k++) begin
            tick();
            n_checks++; if ({bus.valid, bus.dout} !== {1'b1, lsb_word(8 * k)}) begin n_fail++; $display("FAIL drain_word%0d: got valid=%b dout=%h expected valid=1 dout=%h", k, bus.valid, bus.dout, lsb_word(8 * k)); end
        end
        n_checks++; if ({bus.empty, bus.wr_data_count, bus.rd_data_space} !== {1'b1, 8'd0, 5'd16}) begin n_fail++; $display("FAIL drain_empty: got empty=%b count=%0d rspace=%0d expected 1/0/16", bus.empty, bus.wr_data_count, bus.rd_data_space); end
        tick();
        bus.rd_en = 1'b0;
        n_checks++; if ({bus.valid, bus.dout} !== {1'b0, 64'h7F7E7D7C7B7A7978}) begin n_fail++; $display("FAIL drain_hold: got valid=%b dout=%h expected valid=0 dout=7f7e7d7c7b7a7978", bus.valid, bus.dout); end
        tick();
        n_checks++; if (bus.valid !== 1'b0) begin n_fail++; $display("FAIL drain_valid_low: got %b expected 0", bus.valid); end
    endtask

    task automatic test_msb();
        apply_reset();
        for (int i = 0; i < 8; i++) begin
            bus_m.wr_en = 1'b1; bus_m.din = 8'(i);
            tick();
        end
        bus_m.wr_en = 1'b0;
        n_checks++; if (bus_m.empty !== 1'b0) begin n_fail++; $display("FAIL msb_empty: got %b expected 0", bus_m.empty); end
        bus_m.rd_en = 1'b1;
        tick();
        bus_m.rd_en = 1'b0;
        n_checks++; if ({bus_m.valid, bus_m.dout} !== {1'b1, 64'h0001020304050607}) begin n_fail++; $display("FAIL msb_dout: got valid=%b dout=%h expected valid=1 dout=0001020304050607", bus_m.valid, bus_m.dout); end
    endtask

    task automatic test_partial();
        apply_reset();
        for (int i = 0; i < 7; i++) push(8'(8'h10 + i));
        n_checks++; if ({bus.empty, bus.rd_data_count, bus.rd_data_space} !== {1'b1, 5'd0, 5'd15}) begin n_fail++; $display("FAIL partial_7: got empty=%b rcount=%0d rspace=%0d expected 1/0/15", bus.empty, bus.rd_data_count, bus.rd_data_space); end
        n_checks++; if ({bus.wr_data_count, bus.wr_data_space} !== {8'd7, 8'd121}) begin n_fail++; $display("FAIL partial_wside: got %0d/%0d expected 7/121", bus.wr_data_count, bus.wr_data_space); end
        pop();
        n_checks++; if ({bus.valid, bus.wr_data_count} !== {1'b0, 8'd7}) begin n_fail++; $display("FAIL partial_read_ignored: got valid=%b count=%0d expected 0/7", bus.valid, bus.wr_data_count); end
        push(8'h17);
        n_checks++; if ({bus.empty, bus.rd_data_count, bus.rd_data_space} !== {1'b0, 5'd1, 5'd15}) begin n_fail++; $display("FAIL partial_8: got empty=%b rcount=%0d rspace=%0d expected 0/1/15", bus.empty, bus.rd_data_count, bus.rd_data_space); end
        pop();
        n_checks++; if ({bus.valid, bus.dout, bus.empty} !== {1'b1, 64'h1716151413121110, 1'b1}) begin n_fail++; $display("FAIL partial_dout: got valid=%b dout=%h empty=%b expected 1/1716151413121110/1", bus.valid, bus.dout, bus.empty); end
    endtask

    task automatic test_full_simul();
        apply_reset();
        for (int i = 0; i < 128; i++) push(8'(i));
        bus.wr_en = 1'b1; bus.rd_en = 1'b1; bus.din = 8'hC5;
        tick();
        idle();
        n_checks++; if ({bus.full, bus.wr_data_count} !== {1'b0, 8'd121}) begin n_fail++; $display("FAIL simul_count: got full=%b count=%0d expected 0/121", bus.full, bus.wr_data_count); end
        n_checks++; if ({bus.rd_data_count, bus.rd_data_space, bus.wr_data_space} !== {5'd15, 5'd0, 8'd7}) begin n_fail++; $display("FAIL simul_space: got rcount=%0d rspace=%0d wspace=%0d expected 15/0/7", bus.rd_data_count, bus.rd_data_space, bus.wr_data_space); end
        n_checks++; if ({bus.valid, bus.dout} !== {1'b1, lsb_word(0)}) begin n_fail++; $display("FAIL simul_dout: got valid=%b dout=%h expected 1/%h", bus.valid, bus.dout, lsb_word(0)); end
        for (int i = 1; i < 8; i++) push(8'(8'hC5 + i));
        n_checks++; if ({bus.full, bus.wr_data_count} !== {1'b1, 8'd128}) begin n_fail++; $display("FAIL wrap_refill: got full=%b count=%0d expected 1/128", bus.full, bus.wr_data_count); end
        bus.rd_en = 1'b1;
        for (int t = 0; t < 16; t++) begin
            logic [63:0] exp;
            tick();
            exp = (t < 15) ? lsb_word(8 * (t + 1)) : lsb_word(32'hC5);
            n_checks++; if (bus.dout !== exp) begin n_fail++; $display("FAIL wrap_word%0d: got %h expected %h", t, bus.dout, exp); end
        end
        bus.rd_en = 1'b0;
        n_checks++; if ({bus.empty, bus.wr_data_count} !== {1'b1, 8'd0}) begin n_fail++; $display("FAIL wrap_empty: got empty=%b count=%0d expected 1/0", bus.empty, bus.wr_data_count); end
    endtask

    task automatic test_mid_reset();
        apply_reset();
        for (int i = 0; i < 20; i++) push(8'(8'h40 + i));
        pop();
        bus.wr_en = 1'b1; bus.rd_en = 1'b1; bus.din = 8'hEE;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        idle();
        n_checks++; if ({bus.full, bus.empty, bus.valid, bus.dout} !== {3'b010, 64'h0}) begin n_fail++; $display("FAIL midrst_state: got flags=%b dout=%h expected 010/0", {bus.full, bus.empty, bus.valid}, bus.dout); end
        n_checks++; if ({bus.wr_data_count, bus.rd_data_count, bus.wr_data_space, bus.rd_data_space} !== {8'd0, 5'd0, 8'd128, 5'd16}) begin n_fail++; $display("FAIL midrst_counts: got %0d/%0d/%0d/%0d expected 0/0/128/16", bus.wr_data_count, bus.rd_data_count, bus.wr_data_space, bus.rd_data_space); end
        for (int i = 0; i < 8; i++) push(8'(8'hA0 + i));
        n_checks++; if ({bus.rd_data_count, bus.wr_data_count} !== {5'd1, 8'd8}) begin n_fail++; $display("FAIL midrst_refill: got rcount=%0d wcount=%0d expected 1/8", bus.rd_data_count, bus.wr_data_count); end
        pop();
        n_checks++; if ({bus.valid, bus.dout} !== {1'b1, 64'hA7A6A5A4A3A2A1A0}) begin n_fail++; $display("FAIL midrst_dout: got valid=%b dout=%h expected 1/a7a6a5a4a3a2a1a0", bus.valid, bus.dout); end
        n_checks++; if ({bus.empty, bus.rd_data_count} !== {1'b1, 5'd0}) begin n_fail++; $display("FAIL midrst_drained: got empty=%b rcount=%0d expected 1/0", bus.empty, bus.rd_data_count); end
    endtask

    initial begin
        idle();
        test_reset();
        test_fill();
        test_drain();
        test_msb();
        test_partial();
        test_full_simul();
        test_mid_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached before completion");
        $fatal(1);
    end
endmodule

// File: doc/sync_fifo_pack.md
SYNC_FIFO_PACK -- requirements
Module: sync_fifo_pack

Interface
- REQ-001 SHALL have parameter INPUT_WIDTH, default 8: width of each write word in bits.
- REQ-002 SHALL have parameter OUTPUT_WIDTH, default 64: width of each read word; OUTPUT_WIDTH = RATIO*INPUT_WIDTH, RATIO a power of 2, RATIO >= 2.
- REQ-003 SHALL have parameter WR_DEPTH, default 128: capacity in write words; WR_DEPTH = RATIO*RD_DEPTH, power of 2.
- REQ-004 SHALL have parameter RD_DEPTH, default 16: capacity in read words.
- REQ-005 SHALL have parameter MODE, default "Standard": read method, "Standard" or "FWFT".
- REQ-006 SHALL have parameter DIRECTION, default "LSB": "LSB" packs the first-written word into the low bits of dout; "MSB" packs it into the high bits.
- REQ-007 SHALL have port sys_clk, input, 1 bit: the single clock; all logic is on its rising edge.
- REQ-008 SHALL have port sys_rst, input, 1 bit: reset, synchronous and active-high.
- REQ-009 SHALL have port wr_en, input, 1 bit: write request.
- REQ-010 SHALL have port din, input, INPUT_WIDTH bits: write data.
- REQ-011 SHALL have port full, output, 1 bit: no write space.
- REQ-012 SHALL have port wr_data_count, output, $clog2(WR_DEPTH)+1 bits: stored write words.
- REQ-013 SHALL have port wr_data_space, output, $clog2(WR_DEPTH)+1 bits: free write words.
- REQ-014 SHALL have port rd_en, input, 1 bit: read request.
- REQ-015 SHALL have port dout, output, OUTPUT_WIDTH bits: read data.
- REQ-016 SHALL have port valid, output, 1 bit: dout carries a read word.
- REQ-017 SHALL have port empty, output, 1 bit: no complete read word stored.
- REQ-018 SHALL have port rd_data_count, output, $clog2(RD_DEPTH)+1 bits: complete read words stored.
- REQ-019 SHALL have port rd_data_space, output, $clog2(RD_DEPTH)+1 bits: free read words.

Function
- REQ-020 SHALL accept a write on every rising edge with wr_en=1 and full=0; wr_en while full SHALL be ignored, with no state change.
- REQ-021 SHALL store write words in arrival order; write words k*RATIO..k*RATIO+RATIO-1 form read word k.
- REQ-022 DIRECTION="LSB": write word j of a group SHALL appear at dout[(j+1)*INPUT_WIDTH-1 : j*INPUT_WIDTH]; "MSB" SHALL use the mirrored slice.
- REQ-023 SHALL accept a read on a rising edge with rd_en=1 and empty=0; rd_en while empty SHALL be ignored.
- REQ-024 SHALL perform the count arithmetic of this requirement, where all counts, flags and space outputs are registered and updated on the same edge as the accepted operation:
  - wr_data_count = stored write words;
  - rd_data_count = wr_data_count / RATIO (floor);
  - wr_data_space = WR_DEPTH - wr_data_count;
  - rd_data_space = RD_DEPTH - ceil(wr_data_count/RATIO).
- REQ-025 SHALL assert full iff wr_data_count = WR_DEPTH, and SHALL assert empty iff rd_data_count = 0 (partial groups do not clear empty).
- REQ-026 SHALL apply an accepted simultaneous write and read in the same edge, with wr_data_count net change = +1 - RATIO.
- REQ-027 A read at full SHALL clear full on that edge.
- REQ-028 A read that leaves a partial group SHALL leave empty=1 until the group completes.
- REQ-029 SHALL wrap read and write pointers modulo depth without loss or duplication.
- REQ-030 MODE="Standard": an accepted read at edge N SHALL present the word on dout with valid=1 during cycle N+1; valid SHALL be 0 otherwise, and dout SHALL hold its last value.
- REQ-031 MODE="FWFT": dout SHALL show the head read word whenever empty=0, valid SHALL equal ~empty, and an accepted read SHALL advance to the next word on the same edge.

Reset
- REQ-032 When sys_rst=1 at a rising edge, the block SHALL clear the pointers and counts and set: full=0, empty=1, valid=0, dout=0, wr_data_count=0, rd_data_count=0, wr_data_space=WR_DEPTH, rd_data_space=RD_DEPTH.
- REQ-033 Reset SHALL override wr_en and rd_en in the same cycle, and reset mid-operation SHALL discard all stored data including partial groups.

Verification
- REQ-034 The bench SHALL cover fill: write bytes 0x00..0x7F -> full=1 after the 128th write, wr_data_count=128, rd_data_count=16, the 129th write is ignored.
- REQ-035 The bench SHALL cover drain with LSB/Standard: 16 reads after fill -> first dout=64'h0706050403020100, last dout=64'h7F7E7D7C7B7A7978, then empty=1 and valid low afterwards.
- REQ-036 The bench SHALL cover MSB: write 0x00..0x07 then read -> dout=64'h0001020304050607.
- REQ-037 The bench SHALL cover a partial group: write 7 bytes -> empty=1, rd_data_count=0, rd_data_space=15; the 8th write -> empty=0 on that edge.
- REQ-038 The bench SHALL cover simultaneous access at full: wr_en=1 and rd_en=1 -> full=0, wr_data_count=121.
- REQ-039 The bench SHALL cover mid-fill reset: sys_rst=1 for 1 cycle after 20 writes -> all outputs at reset values, and the next 8 writes produce a single read word of those 8 bytes.
